controle_multiciclo: RTL and testbench

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

---
 rtl/controle_multiciclo.sv | 217 +++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// ---------------------------------------------------------------------------
// controle_multiciclo
//
// Purpose:
//   Control unit for a small multicycle MIPS-like datapath. A six-state FSM
//   walks every instruction through fetch, decode, execute, an optional
//   memory phase and an optional write-back phase. It drives the datapath
//   strobes and selectors for each phase and pulses instr_concluida in the
//   cycle an instruction retires.
//
// Ports:
//   clock           in   1  rising-edge system clock
//   reset           in   1  asynchronous, active-low reset
//   iniciar         in   1  start request, only looked at while idle
//   opcode          in   3  instruction opcode, captured when leaving decode
//   mem_pronto      in   1  memory access complete
//   estado          out  3  current FSM state code
//   pc_escrita      out  1  PC write enable
//   ir_escrita      out  1  instruction register write enable
//   ula_opcode      out  2  ALU op: 00 add, 01 sub, 10 funct, 11 and
//   reg_dest        out  2  destination register: 00 rt, 01 rd, 10 $ra
//   mem_to_reg      out  2  writeback source: 00 ALU, 01 memory, 10 PC+4
//   ula_src         out  1  ALU B operand from immediate
//   mem_escrita     out  1  memory write strobe
//   mem_leitura     out  1  memory read strobe
//   reg_escrita     out  1  register file write enable
//   branch          out  1  conditional branch
//   jump            out  1  unconditional jump
//   sign_zero       out  1  1 = sign-extend immediate, 0 = zero-extend
//   instr_concluida out  1  one-cycle pulse on instruction retire
// ---------------------------------------------------------------------------
module controle_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [2:0] opcode,
  input  logic       mem_pronto,
  output logic [2:0] estado,
  output logic       pc_escrita,
  output logic       ir_escrita,
  output logic [1:0] ula_opcode,
  output logic [1:0] reg_dest,
  output logic [1:0] mem_to_reg,
  output logic       ula_src,
  output logic       mem_escrita,
  output logic       mem_leitura,
  output logic       reg_escrita,
  output logic       branch,
  output logic       jump,
  output logic       sign_zero,
  output logic       instr_concluida
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'b000,
    BUSCA      = 3'b001,
    DECODIFICA = 3'b010,
    EXECUTA    = 3'b011,
    MEMORIA    = 3'b100,
    ESCRITA    = 3'b101
  } estado_t;

  typedef enum logic [2:0] {
    OP_TIPO_R = 3'b000,
    OP_ADDI   = 3'b001,
    OP_ANDI   = 3'b010,
    OP_LW     = 3'b011,
    OP_SW     = 3'b100,
    OP_BEQ    = 3'b101,
    OP_J      = 3'b110,
    OP_JAL    = 3'b111
  } opcode_t;

  estado_t state_q, state_d;
  opcode_t op_reg_q, op_reg_d;

  // State and latched opcode. Reset clears both immediately, which also
  // forces every combinational output low since they decode from these.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      op_reg_q <= OP_TIPO_R;
    end else begin
      state_q  <= state_d;
      op_reg_q <= op_reg_d;
    end
  end

  // Next-state logic. The opcode is only sampled in decode so that later
  // changes on the opcode input cannot disturb the instruction in flight.
  // Unused state codes fall back to idle.
  always_comb begin
    state_d  = state_q;
    op_reg_d = op_reg_q;
    case (state_q)
      OCIOSO: begin
        if (iniciar) state_d = BUSCA;
      end
      BUSCA: begin
        if (mem_pronto) state_d = DECODIFICA;
      end
      DECODIFICA: begin
        op_reg_d = opcode_t'(opcode);
        state_d  = EXECUTA;
      end
      EXECUTA: begin
        case (op_reg_q)
          OP_TIPO_R, OP_ADDI, OP_ANDI, OP_JAL: state_d = ESCRITA;
          OP_LW, OP_SW:                        state_d = MEMORIA;
          OP_BEQ, OP_J:                        state_d = BUSCA;
          default:                             state_d = BUSCA;
        endcase
      end
      MEMORIA: begin
        if (mem_pronto) state_d = (op_reg_q == OP_LW) ? ESCRITA : BUSCA;
      end
      ESCRITA: begin
        state_d = BUSCA;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // Output decode. Everything defaults low; each state raises only the
  // controls its phase needs. Fetch and memory completion strobes depend
  // on mem_pronto directly so they act in the same cycle memory answers.
  always_comb begin
    pc_escrita      = 1'b0;
    ir_escrita      = 1'b0;
    ula_opcode      = 2'b00;
    reg_dest        = 2'b00;
    mem_to_reg      = 2'b00;
    ula_src         = 1'b0;
    mem_escrita     = 1'b0;
    mem_leitura     = 1'b0;
    reg_escrita     = 1'b0;
    branch          = 1'b0;
    jump            = 1'b0;
    sign_zero       = 1'b0;
    instr_concluida = 1'b0;
    case (state_q)
      BUSCA: begin
        mem_leitura = 1'b1;
        if (mem_pronto) begin
          ir_escrita = 1'b1;
          pc_escrita = 1'b1;
        end
      end
      EXECUTA: begin
        case (op_reg_q)
          OP_TIPO_R: begin
            ula_opcode = 2'b10;
          end
          OP_ADDI: begin
            ula_src   = 1'b1;
            sign_zero = 1'b1;
          end
          OP_ANDI: begin
            ula_src    = 1'b1;
            ula_opcode = 2'b11;
          end
          OP_LW, OP_SW: begin
            ula_src   = 1'b1;
            sign_zero = 1'b1;
          end
          OP_BEQ: begin
            ula_opcode      = 2'b01;
            branch          = 1'b1;
            sign_zero       = 1'b1;
            instr_concluida = 1'b1;
          end
          OP_J: begin
            jump            = 1'b1;
            pc_escrita      = 1'b1;
            instr_concluida = 1'b1;
          end
          OP_JAL: begin
            jump       = 1'b1;
            pc_escrita = 1'b1;
          end
          default: begin
          end
        endcase
      end
      MEMORIA: begin
        // The strobe is held for the whole wait; a store retires here.
        if (op_reg_q == OP_LW) begin
          mem_leitura = 1'b1;
        end else begin
          mem_escrita = 1'b1;
          if (mem_pronto) instr_concluida = 1'b1;
        end
      end
      ESCRITA: begin
        reg_escrita     = 1'b1;
        instr_concluida = 1'b1;
        case (op_reg_q)
          OP_TIPO_R: reg_dest = 2'b01;
          OP_LW:     mem_to_reg = 2'b01;
          OP_JAL: begin
            reg_dest   = 2'b10;
            mem_to_reg = 2'b10;
          end
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_controle_multiciclo
//
// Purpose:
//   Self-checking bench for controle_multiciclo. A table of per-cycle
//   records {inputs, expected state, expected controls} drives the
//   instruction sweep and the wait-state cases; a hand-written sequence
//   covers asynchronous reset in the middle of a store.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_controle_multiciclo;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [2:0] opcode;
  logic       mem_pronto;
  logic [2:0] estado;
  logic       pc_escrita;
  logic       ir_escrita;
  logic [1:0] ula_opcode;
  logic [1:0] reg_dest;
  logic [1:0] mem_to_reg;
  logic       ula_src;
  logic       mem_escrita;
  logic       mem_leitura;
  logic       reg_escrita;
  logic       branch;
  logic       jump;
  logic       sign_zero;
  logic       instr_concluida;

  int compared   = 0;
  int mismatched = 0;

  controle_multiciclo dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .opcode          (opcode),
    .mem_pronto      (mem_pronto),
    .estado          (estado),
    .pc_escrita      (pc_escrita),
    .ir_escrita      (ir_escrita),
    .ula_opcode      (ula_opcode),
    .reg_dest        (reg_dest),
    .mem_to_reg      (mem_to_reg),
    .ula_src         (ula_src),
    .mem_escrita     (mem_escrita),
    .mem_leitura     (mem_leitura),
    .reg_escrita     (reg_escrita),
    .branch          (branch),
    .jump            (jump),
    .sign_zero       (sign_zero),
    .instr_concluida (instr_concluida)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Control bits packed for one-shot comparison.
  logic [15:0] actCtrl;
  assign actCtrl = {pc_escrita, ir_escrita, ula_opcode, reg_dest, mem_to_reg,
                    ula_src, mem_escrita, mem_leitura, reg_escrita,
                    branch, jump, sign_zero, instr_concluida};

  localparam logic [15:0] PC      = 16'h8000;
  localparam logic [15:0] IR      = 16'h4000;
  localparam logic [15:0] ULA_SUB = 16'h1000;
  localparam logic [15:0] ULA_FN  = 16'h2000;
  localparam logic [15:0] ULA_AND = 16'h3000;
  localparam logic [15:0] RD_RD   = 16'h0400;
  localparam logic [15:0] RD_RA   = 16'h0800;
  localparam logic [15:0] M2R_MEM = 16'h0100;
  localparam logic [15:0] M2R_PC  = 16'h0200;
  localparam logic [15:0] SRC     = 16'h0080;
  localparam logic [15:0] MW      = 16'h0040;
  localparam logic [15:0] MR      = 16'h0020;
  localparam logic [15:0] RW      = 16'h0010;
  localparam logic [15:0] BR      = 16'h0008;
  localparam logic [15:0] JMP     = 16'h0004;
  localparam logic [15:0] SZ      = 16'h0002;
  localparam logic [15:0] DONE    = 16'h0001;
  localparam logic [15:0] NONE    = 16'h0000;

  localparam logic [2:0] S_OC = 3'b000;
  localparam logic [2:0] S_BU = 3'b001;
  localparam logic [2:0] S_DE = 3'b010;
  localparam logic [2:0] S_EX = 3'b011;
  localparam logic [2:0] S_ME = 3'b100;
  localparam logic [2:0] S_ES = 3'b101;

  typedef struct packed {
    logic        iniciar;
    logic [2:0]  opcode;
    logic        memPronto;
    logic [2:0]  expEstado;
    logic [15:0] expCtrl;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic ini, input logic [2:0] op,
                                 input logic mp, input logic [2:0] st,
                                 input logic [15:0] ctl);
    vec_t v;
    v.iniciar   = ini;
    v.opcode    = op;
    v.memPronto = mp;
    v.expEstado = st;
    v.expCtrl   = ctl;
    vecs.push_back(v);
  endfunction

  // Fetch with memory ready at once, then decode.
  function automatic void addFetch(input logic [2:0] op);
    addVec(1'b0, op, 1'b1, S_BU, MR | IR | PC);
    addVec(1'b0, op, 1'b1, S_DE, NONE);
  endfunction

  // Drive inputs just after the falling edge and let them settle.
  task automatic applyStimulus(input logic ini, input logic [2:0] op,
                               input logic mp);
    @(negedge clock);
    iniciar    = ini;
    opcode     = op;
    mem_pronto = mp;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expE,
                             input logic [15:0] expC);
    compared++;
    if (estado !== expE) begin
      mismatched++;
      $display("[TB] FAIL %s estado: got %b expected %b", name, estado, expE);
    end
    compared++;
    if (actCtrl !== expC) begin
      mismatched++;
      $display("[TB] FAIL %s controls: got %h expected %h", name, actCtrl, expC);
    end
  endtask

  initial begin
    reset      = 1'b0;
    iniciar    = 1'b0;
    opcode     = 3'b000;
    mem_pronto = 1'b1;

    // Idle start: hold reset over a couple of edges, with iniciar high to
    // show it is ignored while reset is low.
    #2 iniciar = 1'b1;
    #15;
    checkOutput("resetHold", S_OC, NONE);
    @(negedge clock);
    iniciar = 1'b0;
    reset   = 1'b1;

    // Idle, then start.
    addVec(1'b0, 3'b000, 1'b1, S_OC, NONE);
    addVec(1'b1, 3'b000, 1'b1, S_OC, NONE);
    // tipo-R: 4 cycles
    addFetch(3'b000);
    addVec(1'b0, 3'b000, 1'b1, S_EX, ULA_FN);
    addVec(1'b0, 3'b000, 1'b1, S_ES, RW | RD_RD | DONE);
    // addi
    addFetch(3'b001);
    addVec(1'b0, 3'b001, 1'b1, S_EX, SRC | SZ);
    addVec(1'b0, 3'b001, 1'b1, S_ES, RW | DONE);
    // andi
    addFetch(3'b010);
    addVec(1'b0, 3'b010, 1'b1, S_EX, SRC | ULA_AND);
    addVec(1'b0, 3'b010, 1'b1, S_ES, RW | DONE);
    // lw: 5 cycles
    addFetch(3'b011);
    addVec(1'b0, 3'b011, 1'b1, S_EX, SRC | SZ);
    addVec(1'b0, 3'b011, 1'b1, S_ME, MR);
    addVec(1'b0, 3'b011, 1'b1, S_ES, RW | M2R_MEM | DONE);
    // sw
    addFetch(3'b100);
    addVec(1'b0, 3'b100, 1'b1, S_EX, SRC | SZ);
    addVec(1'b0, 3'b100, 1'b1, S_ME, MW | DONE);
    // beq: 3 cycles
    addFetch(3'b101);
    addVec(1'b0, 3'b101, 1'b1, S_EX, ULA_SUB | BR | SZ | DONE);
    // j
    addFetch(3'b110);
    addVec(1'b0, 3'b110, 1'b1, S_EX, JMP | PC | DONE);
    // jal: 4 cycles
    addFetch(3'b111);
    addVec(1'b0, 3'b111, 1'b1, S_EX, JMP | PC);
    addVec(1'b0, 3'b111, 1'b1, S_ES, RW | RD_RA | M2R_PC | DONE);
    // Fetch wait of 3 cycles, then a beq to finish the instruction.
    addVec(1'b0, 3'b101, 1'b0, S_BU, MR);
    addVec(1'b0, 3'b101, 1'b0, S_BU, MR);
    addVec(1'b0, 3'b101, 1'b0, S_BU, MR);
    addVec(1'b0, 3'b101, 1'b1, S_BU, MR | IR | PC);
    addVec(1'b0, 3'b101, 1'b1, S_DE, NONE);
    addVec(1'b0, 3'b101, 1'b1, S_EX, ULA_SUB | BR | SZ | DONE);
    // lw with two memory wait cycles: 7 cycles total.
    addFetch(3'b011);
    addVec(1'b0, 3'b011, 1'b1, S_EX, SRC | SZ);
    addVec(1'b0, 3'b011, 1'b0, S_ME, MR);
    addVec(1'b0, 3'b011, 1'b0, S_ME, MR);
    addVec(1'b0, 3'b011, 1'b1, S_ME, MR);
    addVec(1'b0, 3'b011, 1'b1, S_ES, RW | M2R_MEM | DONE);
    // Opcode isolation: lw captured, opcode input flips to 000 afterwards.
    addFetch(3'b011);
    addVec(1'b0, 3'b000, 1'b1, S_EX, SRC | SZ);
    addVec(1'b0, 3'b000, 1'b1, S_ME, MR);
    addVec(1'b0, 3'b000, 1'b1, S_ES, RW | M2R_MEM | DONE);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iniciar, vecs[i].opcode, vecs[i].memPronto);
      checkOutput($sformatf("vec%0d", i), vecs[i].expEstado, vecs[i].expCtrl);
    end

    // Reset in the middle of a store waiting on memory.
    applyStimulus(1'b0, 3'b100, 1'b1);
    checkOutput("swBusca", S_BU, MR | IR | PC);
    applyStimulus(1'b0, 3'b100, 1'b1);
    checkOutput("swDecod", S_DE, NONE);
    applyStimulus(1'b0, 3'b100, 1'b1);
    checkOutput("swExec", S_EX, SRC | SZ);
    applyStimulus(1'b0, 3'b100, 1'b0);
    checkOutput("swMemWait", S_ME, MW);
    #1 reset = 1'b0;
    #1;
    checkOutput("rstMidMem", S_OC, NONE);
    @(negedge clock);
    #1;
    checkOutput("rstHeld", S_OC, NONE);
    reset = 1'b1;
    #1;
    checkOutput("rstRelease", S_OC, NONE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'b100, 1'b1);
      checkOutput($sformatf("idleAfterRst%0d", i), S_OC, NONE);
    end
    applyStimulus(1'b1, 3'b000, 1'b1);
    checkOutput("restartIdle", S_OC, NONE);
    applyStimulus(1'b0, 3'b000, 1'b1);
    checkOutput("restartBusca", S_BU, MR | IR | PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
